rv32i_mmu: RTL and testbench

Parametrised memory management unit between the RV32I multicycle core and the system RAM, replacing the fixed word-address slice in the system top. Decodes every core access into a RAM region or a memory-mapped I/O region, generates byte-lane write strobes for byte/half/word stores, and hosts the first on-chip peripherals:

- GPIO output register.
- Synchronised GPIO input.
- 64-bit cycle counter with compare interrupt.
- Sticky status register.

---
 rtl/rv32i_mmu.sv | 168 ++++++++++++++++
 tb/tb_rv32i_mmu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mmu.sv
// rv32i_mmu: address decode, byte-lane strobes and first MMIO peripherals
// (GPIO out/in, 64-bit cycle counter with compare, sticky status) between
// the RV32I multicycle core and system RAM.
module rv32i_mmu #(
  parameter int          RAM_L     = 65536,
  parameter int          GPIO_W    = 32,
  parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [31:0]              core_mem_addr,
  input  logic                     core_mem_wr_ena,
  input  logic [1:0]               core_mem_size,
  input  logic [31:0]              core_mem_wr_data,
  output logic [31:0]              core_mem_rd_data,
  output logic [$clog2(RAM_L)-1:0] ram_addr,
  output logic                     ram_wr_ena,
  output logic [3:0]               ram_wr_strb,
  output logic [31:0]              ram_wr_data,
  input  logic [31:0]              ram_rd_data,
  input  logic [GPIO_W-1:0]        gpio_in,
  output logic [GPIO_W-1:0]        gpio_out,
  output logic                     timer_irq
);

  localparam int          AW        = $clog2(RAM_L);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_L) * 33'd4;

  localparam logic [13:0] IDX_GPIO_OUT  = 14'd0;
  localparam logic [13:0] IDX_GPIO_IN   = 14'd1;
  localparam logic [13:0] IDX_CYCLE_LO  = 14'd2;
  localparam logic [13:0] IDX_CYCLE_HI  = 14'd3;
  localparam logic [13:0] IDX_TIMER_CMP = 14'd4;
  localparam logic [13:0] IDX_STATUS    = 14'd5;

  logic              in_ram;
  logic              in_mmio;
  logic              unmapped;
  logic [13:0]       word_idx;
  logic [3:0]        strb;
  logic              misaligned;
  logic              commit;
  logic              mmio_wr;
  logic              reg_defined;
  logic              reg_ro;
  logic              fault;
  logic              timer_match;
  logic [1:0]        status_clr;
  logic [1:0]        status_set;
  logic [31:0]       gpio_out_word;
  logic [31:0]       gpio_in_word;
  logic [31:0]       gpio_merged;
  logic [31:0]       cmp_merged;
  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;
  logic [63:0]       cycle_cnt;
  logic [31:0]       timer_cmp;
  logic [1:0]        status;

  // Replace the byte lanes selected by s with the matching lanes of data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

  assign ram_addr    = core_mem_addr[AW+1:2];
  assign ram_wr_data = core_mem_wr_data;
  assign ram_wr_strb = strb;
  assign word_idx    = core_mem_addr[15:2];
  assign timer_irq   = status[0];

  // Region decode; RAM takes priority should the two windows ever overlap.
  always_comb begin
    in_ram      = ({1'b0, core_mem_addr} < RAM_BYTES);
    in_mmio     = !in_ram && (core_mem_addr[31:16] == MMIO_BASE[31:16]);
    unmapped    = !in_ram && !in_mmio;
    reg_defined = (word_idx <= IDX_STATUS);
    reg_ro      = (word_idx == IDX_GPIO_IN) || (word_idx == IDX_CYCLE_LO) ||
                  (word_idx == IDX_CYCLE_HI);
  end

  // Byte-lane strobes; an all-zero strobe marks a misaligned or reserved-size store.
  always_comb begin
    strb = 4'b0000;
    case (core_mem_size)
      2'd0: strb = 4'b0001 << core_mem_addr[1:0];
      2'd1: if (!core_mem_addr[0]) strb = 4'b0011 << core_mem_addr[1:0];
      2'd2: if (core_mem_addr[1:0] == 2'b00) strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    misaligned = (strb == 4'b0000);
  end

  // Commit qualification, fault detection and status set/clear terms.
  always_comb begin
    commit      = ena && core_mem_wr_ena && !misaligned;
    ram_wr_ena  = commit && in_ram;
    mmio_wr     = commit && in_mmio;
    fault       = ena && core_mem_wr_ena &&
                  (unmapped || misaligned || (in_mmio && (!reg_defined || reg_ro)));
    timer_match = ena && (timer_cmp != 32'd0) && (cycle_cnt[31:0] == timer_cmp);
    status_clr  = (mmio_wr && (word_idx == IDX_STATUS) && strb[0]) ?
                  core_mem_wr_data[1:0] : 2'b00;
    status_set  = {fault, timer_match};
  end

  // Zero-extend the narrow GPIO registers to bus width and prepare merges.
  always_comb begin
    gpio_out_word             = 32'd0;
    gpio_out_word[GPIO_W-1:0] = gpio_out;
    gpio_in_word              = 32'd0;
    gpio_in_word[GPIO_W-1:0]  = sync2;
    gpio_merged               = merge_bytes(gpio_out_word, core_mem_wr_data, strb);
    cmp_merged                = merge_bytes(timer_cmp, core_mem_wr_data, strb);
  end

  // Read mux: RAM data, MMIO register word, or zero when unmapped.
  always_comb begin
    core_mem_rd_data = 32'd0;
    if (in_ram) begin
      core_mem_rd_data = ram_rd_data;
    end else if (in_mmio) begin
      case (word_idx)
        IDX_GPIO_OUT:  core_mem_rd_data = gpio_out_word;
        IDX_GPIO_IN:   core_mem_rd_data = gpio_in_word;
        IDX_CYCLE_LO:  core_mem_rd_data = cycle_cnt[31:0];
        IDX_CYCLE_HI:  core_mem_rd_data = cycle_cnt[63:32];
        IDX_TIMER_CMP: core_mem_rd_data = timer_cmp;
        IDX_STATUS:    core_mem_rd_data = {30'd0, status};
        default:       core_mem_rd_data = 32'd0;
      endcase
    end
  end

  // Two-flop synchroniser for gpio_in; runs regardless of ena.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  // Peripheral state: counter, GPIO_OUT, TIMER_CMP and sticky STATUS, all frozen when ena is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= 64'd0;
      gpio_out  <= '0;
      timer_cmp <= 32'd0;
      status    <= 2'b00;
    end else if (ena) begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (mmio_wr && (word_idx == IDX_GPIO_OUT))  gpio_out  <= gpio_merged[GPIO_W-1:0];
      if (mmio_wr && (word_idx == IDX_TIMER_CMP)) timer_cmp <= cmp_merged;
      status <= (status & ~status_clr) | status_set;
    end
  end

endmodule

// File: tb/tb_rv32i_mmu.sv
// Self-checking bench for rv32i_mmu: a scoreboard queue of expected values
// is filled as stimulus is driven and drained against DUT observations.
module tb_rv32i_mmu;

  localparam int          RAM_L  = 256;
  localparam int          GPIO_W = 16;
  localparam logic [31:0] MMIO   = 32'hF000_0000;
  localparam logic [31:0] A_GPIO_OUT = MMIO + 32'h00;
  localparam logic [31:0] A_GPIO_IN  = MMIO + 32'h04;
  localparam logic [31:0] A_CYC_LO   = MMIO + 32'h08;
  localparam logic [31:0] A_CYC_HI   = MMIO + 32'h0C;
  localparam logic [31:0] A_CMP      = MMIO + 32'h10;
  localparam logic [31:0] A_STATUS   = MMIO + 32'h14;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ena = 1'b1;
  logic [31:0]       core_mem_addr = 32'd0;
  logic              core_mem_wr_ena = 1'b0;
  logic [1:0]        core_mem_size = 2'd2;
  logic [31:0]       core_mem_wr_data = 32'd0;
  logic [31:0]       core_mem_rd_data;
  logic [7:0]        ram_addr;
  logic              ram_wr_ena;
  logic [3:0]        ram_wr_strb;
  logic [31:0]       ram_wr_data;
  logic [31:0]       ram_rd_data;
  logic [GPIO_W-1:0] gpio_in = '0;
  logic [GPIO_W-1:0] gpio_out;
  logic              timer_irq;

  logic [31:0] mem [0:RAM_L-1];
  logic [63:0] model_cnt;

  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  string       name_q [$];
  int          tests_run = 0;
  int          tests_failed = 0;

  rv32i_mmu #(.RAM_L(RAM_L), .GPIO_W(GPIO_W), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .core_mem_addr(core_mem_addr), .core_mem_wr_ena(core_mem_wr_ena),
    .core_mem_size(core_mem_size), .core_mem_wr_data(core_mem_wr_data),
    .core_mem_rd_data(core_mem_rd_data), .ram_addr(ram_addr),
    .ram_wr_ena(ram_wr_ena), .ram_wr_strb(ram_wr_strb), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with byte-lane writes and combinational read.
  assign ram_rd_data = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_wr_ena) begin
      for (int i = 0; i < 4; i++)
        if (ram_wr_strb[i]) mem[ram_addr][8*i +: 8] <= ram_wr_data[8*i +: 8];
    end
  end

  // Reference cycle count: edges seen since reset while ena is high.
  always @(posedge clk or negedge rst) begin
    if (!rst) model_cnt <= 64'd0;
    else if (ena) model_cnt <= model_cnt + 64'd1;
  end

  task automatic sb_push(input string n, input logic [31:0] e);
    name_q.push_back(n);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read(input logic [31:0] a, output logic [31:0] d);
    core_mem_wr_ena = 1'b0;
    core_mem_addr = a;
    #1;
    d = core_mem_rd_data;
  endtask

  // Drives one store for one edge; reports strobe/enable seen before the edge.
  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                       output logic [3:0] s, output logic we);
    core_mem_addr = a;
    core_mem_size = sz;
    core_mem_wr_data = d;
    core_mem_wr_ena = 1'b1;
    #1;
    s = ram_wr_strb;
    we = ram_wr_ena;
    @(posedge clk);
    @(negedge clk);
    core_mem_wr_ena = 1'b0;
  endtask

  task automatic do_reset();
    core_mem_wr_ena = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic advance_to(input logic [63:0] target);
    int b = 0;
    while (model_cnt != target && b < 200) begin
      step();
      b++;
    end
    if (model_cnt != target) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL advance_timeout: count %0d required %0d", model_cnt, target);
    end
  endtask

  task automatic drain();
    logic [31:0] e, o;
    string n;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n = name_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL %s: got 0x%08h required 0x%08h", n, o, e);
      end
    end
    if (exp_q.size() != obs_q.size()) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_size: got %0d required %0d", obs_q.size(), exp_q.size());
      exp_q.delete(); obs_q.delete(); name_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sb_push("rst_gpio_out", 32'd0);   obs_q.push_back(32'(gpio_out));
    sb_push("rst_irq", 32'd0);        obs_q.push_back(32'(timer_irq));
    sb_push("rst_cycle_lo", 32'd0);   read(A_CYC_LO, d); obs_q.push_back(d);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) step();
    sb_push("cycle_lo_10", 32'd10);   read(A_CYC_LO, d); obs_q.push_back(d);
    sb_push("cycle_hi_0", 32'd0);     read(A_CYC_HI, d); obs_q.push_back(d);
    sb_push("status_0", 32'd0);       read(A_STATUS, d); obs_q.push_back(d);
    sb_push("irq_0", 32'd0);          obs_q.push_back(32'(timer_irq));
    drain();
  endtask

  task automatic test_ram_stores();
    logic [31:0] d; logic [3:0] s; logic we;
    sb_push("word_strb", 32'hF);  sb_push("word_we", 32'd1);
    store(32'h100, 2'd2, 32'h1122_3344, s, we); obs_q.push_back(32'(s)); obs_q.push_back(32'(we));
    sb_push("word_rd", 32'h1122_3344); read(32'h100, d); obs_q.push_back(d);
    sb_push("byte_strb", 32'h2);
    store(32'h101, 2'd0, 32'h0000_AA00, s, we); obs_q.push_back(32'(s));
    sb_push("byte_rd", 32'h1122_AA44); read(32'h100, d); obs_q.push_back(d);
    sb_push("half_strb", 32'hC);
    store(32'h102, 2'd1, 32'hBEEF_0000, s, we); obs_q.push_back(32'(s));
    sb_push("half_rd", 32'hBEEF_AA44); read(32'h100, d); obs_q.push_back(d);
    sb_push("status_clean", 32'd0); read(A_STATUS, d); obs_q.push_back(d);
    drain();
  endtask

  task automatic test_misaligned();
    logic [31:0] d; logic [3:0] s; logic we;
    sb_push("misal_we", 32'd0); sb_push("misal_strb", 32'd0);
    store(32'h102, 2'd2, 32'hDEAD_BEEF, s, we); obs_q.push_back(32'(we)); obs_q.push_back(32'(s));
    sb_push("misal_status", 32'h2); read(A_STATUS, d); obs_q.push_back(d);
    sb_push("misal_ram_kept", 32'hBEEF_AA44); read(32'h100, d); obs_q.push_back(d);
    store(A_STATUS, 2'd2, 32'h2, s, we);
    sb_push("w1c_status", 32'd0); read(A_STATUS, d); obs_q.push_back(d);
    sb_push("unmapped_we", 32'd0);
    store(32'h8000_0000, 2'd2, 32'h1234, s, we); obs_q.push_back(32'(we));
    sb_push("unmapped_status", 32'h2); read(A_STATUS, d); obs_q.push_back(d);
    sb_push("unmapped_rd", 32'd0); read(32'h8000_0000, d); obs_q.push_back(d);
    store(A_STATUS, 2'd2, 32'h2, s, we);
    sb_push("size3_we", 32'd0);
    store(32'h104, 2'd3, 32'h5555_5555, s, we); obs_q.push_back(32'(we));
    sb_push("size3_status", 32'h2); read(A_STATUS, d); obs_q.push_back(d);
    store(A_STATUS, 2'd2, 32'h2, s, we);
    sb_push("undef_off_rd", 32'd0); read(MMIO + 32'h40, d); obs_q.push_back(d);
    store(MMIO + 32'h40, 2'd2, 32'h1, s, we);
    sb_push("undef_off_status", 32'h2); read(A_STATUS, d); obs_q.push_back(d);
    store(A_STATUS, 2'd0, 32'h3, s, we);
    sb_push("status_cleared", 32'd0); read(A_STATUS, d); obs_q.push_back(d);
    drain();
  endtask

  task automatic test_gpio();
    logic [31:0] d; logic [3:0] s; logic we;
    store(A_GPIO_OUT, 2'd0, 32'h5A, s, we);
    sb_push("gpio_out_5a", 32'h5A); obs_q.push_back(32'(gpio_out));
    store(A_GPIO_OUT + 32'd2, 2'd1, 32'h1234_0000, s, we);
    sb_push("gpio_upper_ignored", 32'h5A); read(A_GPIO_OUT, d); obs_q.push_back(d);
    store(A_GPIO_OUT + 32'd1, 2'd0, 32'h0000_C300, s, we);
    sb_push("gpio_lane1", 32'hC35A); read(A_GPIO_OUT, d); obs_q.push_back(d);
    store(A_GPIO_IN, 2'd2, 32'hFFFF, s, we);
    sb_push("ro_fault", 32'h2); read(A_STATUS, d); obs_q.push_back(d);
    store(A_STATUS, 2'd2, 32'h2, s, we);
    gpio_in = 16'h0003;
    sb_push("gpio_in_0edge", 32'd0); read(A_GPIO_IN, d); obs_q.push_back(d);
    step();
    sb_push("gpio_in_1edge", 32'd0); read(A_GPIO_IN, d); obs_q.push_back(d);
    step();
    sb_push("gpio_in_2edge", 32'h3); read(A_GPIO_IN, d); obs_q.push_back(d);
    drain();
  endtask

  task automatic test_timer();
    logic [31:0] d; logic [3:0] s; logic we; logic [63:0] c;
    do_reset();
    store(A_CMP, 2'd2, 32'd20, s, we);
    advance_to(64'd20);
    sb_push("cmp_cycle_lo", 32'd20); read(A_CYC_LO, d); obs_q.push_back(d);
    sb_push("irq_before_match", 32'd0); obs_q.push_back(32'(timer_irq));
    step();
    sb_push("irq_after_match", 32'd1); obs_q.push_back(32'(timer_irq));
    sb_push("status_match", 32'h1); read(A_STATUS, d); obs_q.push_back(d);
    c = model_cnt;
    store(A_CMP, 2'd2, c[31:0] + 32'd3, s, we);
    advance_to(c + 64'd3);
    store(A_STATUS, 2'd2, 32'h1, s, we);
    sb_push("set_beats_w1c", 32'h1); read(A_STATUS, d); obs_q.push_back(d);
    store(A_STATUS, 2'd2, 32'h1, s, we);
    sb_push("w1c_alone", 32'h0); read(A_STATUS, d); obs_q.push_back(d);
    sb_push("irq_cleared", 32'd0); obs_q.push_back(32'(timer_irq));
    store(A_CMP, 2'd2, 32'd0, s, we);
    for (int i = 0; i < 40; i++) step();
    sb_push("cmp0_no_fire", 32'd0); read(A_STATUS, d); obs_q.push_back(d);
    drain();
  endtask

  task automatic test_freeze_reset();
    logic [31:0] d; logic [3:0] s; logic we;
    store(A_GPIO_OUT, 2'd0, 32'hA5, s, we);
    ena = 1'b0;
    sb_push("freeze_ram_we", 32'd0);
    store(32'h100, 2'd2, 32'hDEAD_0001, s, we); obs_q.push_back(32'(we));
    store(A_GPIO_OUT, 2'd0, 32'hFF, s, we);
    store(32'h8000_0000, 2'd2, 32'h1, s, we);
    for (int i = 0; i < 2; i++) step();
    sb_push("freeze_cycle_lo", model_cnt[31:0]); read(A_CYC_LO, d); obs_q.push_back(d);
    sb_push("freeze_ram", 32'hBEEF_AA44); read(32'h100, d); obs_q.push_back(d);
    sb_push("freeze_gpio", 32'hA5); obs_q.push_back(32'(gpio_out));
    sb_push("freeze_status", 32'd0); read(A_STATUS, d); obs_q.push_back(d);
    ena = 1'b1;
    store(32'h8000_0000, 2'd2, 32'h1, s, we);
    sb_push("pre_reset_status", 32'h2); read(A_STATUS, d); obs_q.push_back(d);
    core_mem_addr = A_GPIO_OUT;
    core_mem_size = 2'd0;
    core_mem_wr_data = 32'h77;
    core_mem_wr_ena = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    sb_push("async_gpio", 32'd0); obs_q.push_back(32'(gpio_out));
    sb_push("async_irq", 32'd0); obs_q.push_back(32'(timer_irq));
    sb_push("async_status", 32'd0); read(A_STATUS, d); obs_q.push_back(d);
    sb_push("async_cycle", 32'd0); read(A_CYC_LO, d); obs_q.push_back(d);
    @(negedge clk);
    rst = 1'b1;
    sb_push("ram_survives", 32'hBEEF_AA44); read(32'h100, d); obs_q.push_back(d);
    drain();
  endtask

  initial begin
    test_reset();
    test_ram_stores();
    test_misaligned();
    test_gpio();
    test_timer();
    test_freeze_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
